// File: rtl/evt_timer.sv
// Prescaled one-shot event timer: counts load_val ticks of PRESCALE cycles,
// then emits a one-cycle timeout_pulse and holds a sticky expired level.
module evt_timer #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_pulse,
  input  logic             stop,
  input  logic [CNT_W-1:0] load_val,
  output logic             timeout_pulse,
  output logic             running,
  output logic             expired,
  output logic [CNT_W-1:0] remaining
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PW-1:0]     r_presc;
  logic [PW-1:0]     w_presc_nxt;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  w_remaining_nxt;
  logic              r_pulse;
  logic              w_pulse_nxt;
  logic              r_running;
  logic              r_expired;
  logic              w_tick;
  logic              w_final;

  assign w_tick  = (r_state == RUN) && (r_presc == PRE_LAST);
  assign w_final = w_tick && (r_remaining <= CNT_W'(1));

  // State register; running/expired are registered from the next state so
  // every output comes straight from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_presc     <= '0;
      r_remaining <= '0;
      r_pulse     <= 1'b0;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_remaining <= w_remaining_nxt;
      r_pulse     <= w_pulse_nxt;
      r_running   <= (w_state_nxt == RUN);
      r_expired   <= (w_state_nxt == EXPIRED);
    end
  end

  // Next-state: stop beats start, start beats tick/expiry.
  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = IDLE;
    end else if (start_pulse) begin
      w_state_nxt = (load_val != '0) ? RUN : EXPIRED;
    end else begin
      case (r_state)
        RUN:     if (w_final) w_state_nxt = EXPIRED;
        EXPIRED: w_state_nxt = EXPIRED;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath/output next values, same priority order as the state logic.
  always_comb begin
    w_presc_nxt     = '0;
    w_remaining_nxt = r_remaining;
    w_pulse_nxt     = 1'b0;
    if (stop) begin
      w_remaining_nxt = '0;
    end else if (start_pulse) begin
      w_remaining_nxt = load_val;
      w_pulse_nxt     = (load_val == '0);
    end else if (r_state == RUN) begin
      if (w_tick) begin
        if (w_final) begin
          w_remaining_nxt = '0;
          w_pulse_nxt     = 1'b1;
        end else begin
          w_remaining_nxt = r_remaining - CNT_W'(1);
        end
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end else if (r_state == EXPIRED) begin
      w_remaining_nxt = '0;
    end
  end

  assign timeout_pulse = r_pulse;
  assign running       = r_running;
  assign expired       = r_expired;
  assign remaining     = r_remaining;

endmodule

// File: tb/tb_evt_timer.sv
// Directed bench for evt_timer (PRESCALE=4, CNT_W=8); samples 1ns after each edge.
`timescale 1ns/1ps
module tb_evt_timer;

  logic       clk;
  logic       reset_n;
  logic       start_pulse;
  logic       stop;
  logic [7:0] load_val;
  logic       timeout_pulse;
  logic       running;
  logic       expired;
  logic [7:0] remaining;

  int checks;
  int errors;

  evt_timer #(.CNT_W(8), .PRESCALE(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_pulse  (start_pulse),
    .stop         (stop),
    .load_val     (load_val),
    .timeout_pulse(timeout_pulse),
    .running      (running),
    .expired      (expired),
    .remaining    (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Apply start for exactly one edge; returns just after that edge (E0).
  task automatic do_start(input logic [7:0] l);
    start_pulse = 1'b1;
    load_val    = l;
    step(1);
    start_pulse = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start_pulse = 1'b0; stop = 1'b0; load_val = '0;
    step(2);
    reset_n = 1'b1;
    step(5);
    checks++;
    if ({timeout_pulse, running, expired} !== 3'b000 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL reset: pulse/run/exp=%b%b%b rem=%0d, required 000 rem=0",
               timeout_pulse, running, expired, remaining);
    end
  endtask

  task automatic test_basic;
    int pulses;
    do_start(8'd3);
    load_val = 8'd200;
    checks++;
    if (remaining !== 8'd3 || running !== 1'b1) begin
      errors++; $display("FAIL basic_e0: rem=%0d run=%b, required 3 1", remaining, running);
    end
    pulses = 0;
    for (int k = 1; k <= 11; k++) begin
      step(1);
      if (timeout_pulse) pulses++;
      if (k == 4) begin
        checks++;
        if (remaining !== 8'd2) begin
          errors++; $display("FAIL basic_e4: rem=%0d, required 2", remaining);
        end
      end
      if (k == 8) begin
        checks++;
        if (remaining !== 8'd1) begin
          errors++; $display("FAIL basic_e8: rem=%0d, required 1", remaining);
        end
      end
    end
    checks++;
    if (running !== 1'b1 || pulses != 0) begin
      errors++; $display("FAIL basic_e11: run=%b pulses=%0d, required 1 0", running, pulses);
    end
    step(1);
    checks++;
    if ({timeout_pulse, running, expired} !== 3'b101 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL basic_e12: pulse/run/exp=%b%b%b rem=%0d, required 101 rem=0",
               timeout_pulse, running, expired, remaining);
    end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (timeout_pulse) pulses++;
    end
    checks++;
    if (pulses != 0 || expired !== 1'b1 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL basic_hold: pulses=%0d exp=%b rem=%0d, required 0 1 0", pulses, expired, remaining);
    end
  endtask

  task automatic test_restart;
    int pulses;
    int at;
    do_start(8'd3);
    step(5);
    do_start(8'd2);
    checks++;
    if (remaining !== 8'd2 || running !== 1'b1) begin
      errors++; $display("FAIL restart_e6: rem=%0d run=%b, required 2 1", remaining, running);
    end
    pulses = 0; at = -1;
    for (int k = 7; k <= 16; k++) begin
      step(1);
      if (timeout_pulse) begin pulses++; at = k; end
    end
    checks++;
    if (pulses != 1 || at != 14) begin
      errors++; $display("FAIL restart_pulse: pulses=%0d at E0+%0d, required 1 at E0+14", pulses, at);
    end
  endtask

  task automatic test_stop;
    int pulses;
    do_start(8'd3);
    step(4);
    stop = 1'b1; step(1); stop = 1'b0;
    checks++;
    if ({timeout_pulse, running, expired} !== 3'b000 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL stop_e5: pulse/run/exp=%b%b%b rem=%0d, required 000 rem=0",
               timeout_pulse, running, expired, remaining);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin step(1); if (timeout_pulse) pulses++; end
    checks++;
    if (pulses != 0 || running !== 1'b0) begin
      errors++; $display("FAIL stop_nopulse: pulses=%0d run=%b, required 0 0", pulses, running);
    end
    do_start(8'd3);
    step(10);
    stop = 1'b1; start_pulse = 1'b1; load_val = 8'd5;
    step(1);
    stop = 1'b0; start_pulse = 1'b0;
    pulses = 0;
    if (timeout_pulse) pulses++;
    checks++;
    if (running !== 1'b0 || remaining !== 8'd0) begin
      errors++; $display("FAIL stop_start: run=%b rem=%0d, required 0 0", running, remaining);
    end
    for (int k = 0; k < 15; k++) begin step(1); if (timeout_pulse) pulses++; end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL stop_start_nopulse: pulses=%0d, required 0", pulses);
    end
  endtask

  task automatic test_final_tick;
    int pulses;
    int at;
    do_start(8'd1);
    step(3);
    do_start(8'd2);
    pulses = 0; at = -1;
    if (timeout_pulse) begin pulses++; at = 4; end
    checks++;
    if (remaining !== 8'd2 || running !== 1'b1) begin
      errors++; $display("FAIL start_final: rem=%0d run=%b, required 2 1", remaining, running);
    end
    for (int k = 5; k <= 14; k++) begin
      step(1);
      if (timeout_pulse) begin pulses++; at = k; end
    end
    checks++;
    if (pulses != 1 || at != 12) begin
      errors++; $display("FAIL start_final_pulse: pulses=%0d at E0+%0d, required 1 at E0+12", pulses, at);
    end
    do_start(8'd1);
    step(3);
    stop = 1'b1; step(1); stop = 1'b0;
    pulses = 0;
    if (timeout_pulse) pulses++;
    for (int k = 0; k < 10; k++) begin step(1); if (timeout_pulse) pulses++; end
    checks++;
    if (pulses != 0 || running !== 1'b0 || expired !== 1'b0) begin
      errors++;
      $display("FAIL stop_final: pulses=%0d run=%b exp=%b, required 0 0 0", pulses, running, expired);
    end
  endtask

  task automatic test_zero_load;
    int at;
    do_start(8'd0);
    checks++;
    if ({timeout_pulse, running, expired} !== 3'b101 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL zero_e0: pulse/run/exp=%b%b%b rem=%0d, required 101 rem=0",
               timeout_pulse, running, expired, remaining);
    end
    step(1);
    checks++;
    if ({timeout_pulse, running, expired} !== 3'b001) begin
      errors++;
      $display("FAIL zero_e1: pulse/run/exp=%b%b%b, required 001", timeout_pulse, running, expired);
    end
    do_start(8'd1);
    checks++;
    if (expired !== 1'b0 || running !== 1'b1) begin
      errors++; $display("FAIL one_e0: exp=%b run=%b, required 0 1", expired, running);
    end
    at = -1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (timeout_pulse && at < 0) at = k;
    end
    checks++;
    if (at != 4) begin
      errors++; $display("FAIL one_pulse: first pulse at E0+%0d, required E0+4", at);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    do_start(8'd3);
    step(7);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({timeout_pulse, running, expired} !== 3'b000 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: pulse/run/exp=%b%b%b rem=%0d, required 000 rem=0",
               timeout_pulse, running, expired, remaining);
    end
    step(2);
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin step(1); if (timeout_pulse) pulses++; end
    checks++;
    if (pulses != 0 || running !== 1'b0 || remaining !== 8'd0) begin
      errors++;
      $display("FAIL reset_nolate: pulses=%0d run=%b rem=%0d, required 0 0 0", pulses, running, remaining);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_basic;
    test_restart;
    test_stop;
    test_final_tick;
    test_zero_load;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
